// File: rtl/i2c_target_fsm.sv
// I2C target (slave) state machine: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match, write bytes to local logic, read bytes from local logic.
// Optional clock stretching on unconsumed write bytes: define I2C_CLK_STRETCH_EN.
module i2c_target_fsm #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AACK, S_RX, S_RACK, S_TX, S_TACK, S_IGNORE, S_WAIT
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [7:0]         sh, sh_n;
  logic [7:0]         rx_data_n;
  logic               sda_oe_n, scl_oe_n, rx_valid_n, tx_req_n, rw_n, busy_n, done_n;
  logic               addressed, addressed_n;
  logic               ack_bit, ack_bit_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_cond, stop_cond;

`ifndef I2C_CLK_STRETCH_EN
  logic unused_rx_ready;
  assign unused_rx_ready = rx_ready;
`endif

  // Pin synchronisers plus one history flop; idle bus level is high
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign sda_rise   = sda_s & ~sda_d;
  assign sda_fall   = ~sda_s & sda_d;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= 8'h00;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addressed <= 1'b0;
      ack_bit   <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      sda_oe    <= sda_oe_n;
      scl_oe    <= scl_oe_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
      rw        <= rw_n;
      busy      <= busy_n;
      done      <= done_n;
      addressed <= addressed_n;
      ack_bit   <= ack_bit_n;
    end
  end

  // Next-state and output logic; bus conditions take priority over data handling
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    sda_oe_n    = sda_oe;
    scl_oe_n    = 1'b0;
    rx_data_n   = rx_data;
`ifdef I2C_CLK_STRETCH_EN
    rx_valid_n  = rx_valid & ~rx_ready;
`else
    rx_valid_n  = 1'b0;
`endif
    tx_req_n    = 1'b0;
    rw_n        = rw;
    busy_n      = busy;
    done_n      = 1'b0;
    addressed_n = addressed;
    ack_bit_n   = ack_bit;

    if (start_cond) begin
      state_n  = S_ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (stop_cond) begin
      state_n     = S_IDLE;
      cnt_n       = '0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
      done_n      = addressed;
      addressed_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            sh_n  = {sh[6:0], sda_s};
            cnt_n = cnt + CNT_W'(1);
          end else if (scl_fall && cnt == CNT_W'(8)) begin
            if (sh[7:1] == TARGET_ADDR) begin
              rw_n        = sh[0];
              sda_oe_n    = 1'b1;
              addressed_n = 1'b1;
              state_n     = S_AACK;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_AACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            busy_n   = 1'b1;
            cnt_n    = '0;
            if (rw) begin
              tx_req_n = 1'b1;
              state_n  = S_TX;
            end else begin
              state_n = S_RX;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            sh_n  = {sh[6:0], sda_s};
            cnt_n = cnt + CNT_W'(1);
          end else if (scl_fall && cnt == CNT_W'(8)) begin
`ifdef I2C_CLK_STRETCH_EN
            if (rx_valid && !rx_ready) begin
              scl_oe_n = 1'b1;
              state_n  = S_WAIT;
            end else begin
              rx_data_n  = sh;
              rx_valid_n = 1'b1;
              sda_oe_n   = 1'b1;
              state_n    = S_RACK;
            end
`else
            rx_data_n  = sh;
            rx_valid_n = 1'b1;
            sda_oe_n   = 1'b1;
            state_n    = S_RACK;
`endif
          end
        end
        S_RACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            cnt_n    = '0;
            state_n  = S_RX;
          end
        end
        S_WAIT: begin
`ifdef I2C_CLK_STRETCH_EN
          // SCL stays held for one extra cycle so the ACK settles before SCL rises
          scl_oe_n = 1'b1;
          if (rx_valid && rx_ready) begin
            rx_data_n  = sh;
            rx_valid_n = 1'b1;
            sda_oe_n   = 1'b1;
            state_n    = S_RACK;
          end
`else
          state_n = S_IDLE;
`endif
        end
        S_TX: begin
          if (tx_req) begin
            sh_n     = tx_data;
            sda_oe_n = ~tx_data[7];
          end else if (scl_fall) begin
            if (cnt == CNT_W'(7)) begin
              sda_oe_n = 1'b0;
              state_n  = S_TACK;
            end else begin
              sda_oe_n = ~sh[6];
              sh_n     = {sh[6:0], 1'b0};
              cnt_n    = cnt + CNT_W'(1);
            end
          end
        end
        S_TACK: begin
          if (scl_rise) begin
            ack_bit_n = sda_s;
          end else if (scl_fall) begin
            if (!ack_bit) begin
              tx_req_n = 1'b1;
              cnt_n    = '0;
              state_n  = S_TX;
            end else begin
              sda_oe_n = 1'b0;
              busy_n   = 1'b0;
              state_n  = S_IGNORE;
            end
          end
        end
        S_IGNORE: sda_oe_n = 1'b0;
        default:  state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Directed bench for i2c_target_fsm: a simple bus master on a wired-AND bus.
module tb_i2c_target_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       scl, sda;
  logic       sda_oe, scl_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_req, rw, busy, done;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0, n_txreq = 0, n_rxv = 0, n_sdaoe = 0, n_scloe = 0;

  assign scl = scl_m & ~scl_oe;
  assign sda = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_fsm #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_req(tx_req), .rw(rw),
    .busy(busy), .done(done)
  );

  // Event counters for pulse outputs
  always @(posedge clk) begin
    n_done  <= n_done + int'(done);
    n_txreq <= n_txreq + int'(tx_req);
    n_rxv   <= n_rxv + int'(rx_valid);
    n_sdaoe <= n_sdaoe + int'(sda_oe);
    n_scloe <= n_scloe + int'(scl_oe);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period; waits out clock stretching, samples SDA mid-high
  task automatic clock_bit(input logic b, output logic s);
    int n;
    sda_m = b;
    wait_clk(4);
    scl_m = 1'b1;
    n = 0;
    while (scl !== 1'b1 && n < 2000) begin
      wait_clk(1);
      n++;
    end
    if (n >= 2000) chk("scl_release_timeout", 32'(n), 32'(0));
    wait_clk(4);
    s = sda;
    wait_clk(4);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    sda_m = 1'b0;
    wait_clk(8);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], d);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_bits(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
  endtask

  initial begin
    logic       ack, d;
    logic [7:0] got;
    int         d_done, d_tx, d_rx, d_oe;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b1; tx_data = 8'h00;
    wait_clk(4);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_scl_oe", 32'(scl_oe), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    reset = 1'b0;
    wait_clk(4);

    // 1: write one byte
    d_done = n_done; d_rx = n_rxv;
    bus_start();
    send_byte(8'hA0, ack);
    chk("t1_addr_ack", 32'(ack), 0);
    chk("t1_busy_hi", 32'(busy), 1);
    chk("t1_rw", 32'(rw), 0);
    send_byte(8'h3C, ack);
    chk("t1_data_ack", 32'(ack), 0);
    chk("t1_rx_data", 32'(rx_data), 32'h3C);
    chk("t1_rx_valid_cycles", 32'(n_rxv - d_rx), 1);
    bus_stop();
    chk("t1_busy_lo", 32'(busy), 0);
    chk("t1_done", 32'(n_done - d_done), 1);

    // 2: read two bytes, master ACK then NACK
    d_done = n_done; d_tx = n_txreq;
    tx_data = 8'h5A;
    bus_start();
    send_byte(8'hA1, ack);
    chk("t2_addr_ack", 32'(ack), 0);
    chk("t2_rw", 32'(rw), 1);
    read_bits(got);
    chk("t2_byte0", 32'(got), 32'h5A);
    tx_data = 8'hC3;
    clock_bit(1'b0, d);
    read_bits(got);
    chk("t2_byte1", 32'(got), 32'hC3);
    clock_bit(1'b1, d);
    chk("t2_nack_busy", 32'(busy), 0);
    chk("t2_nack_sda", 32'(sda_oe), 0);
    bus_stop();
    chk("t2_tx_req", 32'(n_txreq - d_tx), 2);
    chk("t2_done", 32'(n_done - d_done), 1);

    // 3: foreign address is ignored
    d_done = n_done; d_oe = n_sdaoe;
    bus_start();
    send_byte(8'h42, ack);
    chk("t3_no_ack", 32'(ack), 1);
    chk("t3_busy", 32'(busy), 0);
    bus_stop();
    chk("t3_sda_never", 32'(n_sdaoe - d_oe), 0);
    chk("t3_no_done", 32'(n_done - d_done), 0);

    // 4: write then repeated START into a read
    tx_data = 8'hA5;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h11, ack);
    chk("t4_data_ack", 32'(ack), 0);
    bus_start();
    send_byte(8'hA1, ack);
    chk("t4_raddr_ack", 32'(ack), 0);
    read_bits(got);
    chk("t4_first_bit", 32'(got[7]), 1);
    chk("t4_read_byte", 32'(got), 32'hA5);
    chk("t4_rx_data", 32'(rx_data), 32'h11);
    chk("t4_rw", 32'(rw), 1);
    clock_bit(1'b1, d);
    bus_stop();

    // 5: reset while the address ACK is driven
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      got = 8'hA0;
      clock_bit(got[i], d);
    end
    chk("t5_ack_driven", 32'(sda_oe), 1);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    chk("t5_rst_sda", 32'(sda_oe), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    wait_clk(8);
    bus_start();
    send_byte(8'hA0, ack);
    chk("t5_reack", 32'(ack), 0);
    bus_stop();

`ifdef I2C_CLK_STRETCH_EN
    // 6: second byte stalls until the first is consumed
    rx_ready = 1'b0;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h01, ack);
    chk("t6_b0_ack", 32'(ack), 0);
    chk("t6_b0_data", 32'(rx_data), 32'h01);
    fork
      send_byte(8'h02, ack);
      begin
        int n;
        n = 0;
        while (scl_oe !== 1'b1 && n < 500) begin
          wait_clk(1);
          n++;
        end
        chk("t6_stretch", 32'(scl_oe), 1);
        wait_clk(20);
        chk("t6_held_data", 32'(rx_data), 32'h01);
        chk("t6_still_held", 32'(scl_oe), 1);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        chk("t6_new_data", 32'(rx_data), 32'h02);
        wait_clk(2);
        chk("t6_released", 32'(scl_oe), 0);
      end
    join
    chk("t6_b1_ack", 32'(ack), 0);
    bus_stop();
    rx_ready = 1'b1;
    wait_clk(2);
`else
    chk("scl_oe_never", 32'(n_scloe), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
